// File: rtl/lpif_tx_asym2_pack_if.sv
// ---------------------------------------------------------------------------
// lpif_tx_asym2_pack_if
// Bundles the two streams around the asym2 pack sequencer:
//   - LPIF beat stream (lpif_beat_data / _vld / _rdy), consumed by the packer.
//   - TX FIFO word stream (txfifo_downstream_data / _vld / _rdy), produced
//     by the packer. The upper BEAT_W bits of a word hold the second beat.
// Modports:
//   slave  : the packer (takes beats, offers FIFO words).
//   master : the environment (offers beats, accepts FIFO words).
// ---------------------------------------------------------------------------
interface lpif_tx_asym2_pack_if #(
    parameter int BEAT_W = 77
);
    logic [BEAT_W-1:0]   lpif_beat_data;
    logic                lpif_beat_vld;
    logic                lpif_beat_rdy;
    logic [2*BEAT_W-1:0] txfifo_downstream_data;
    logic                txfifo_downstream_vld;
    logic                txfifo_downstream_rdy;

    modport slave (
        input  lpif_beat_data,
        input  lpif_beat_vld,
        output lpif_beat_rdy,
        output txfifo_downstream_data,
        output txfifo_downstream_vld,
        input  txfifo_downstream_rdy
    );

    modport master (
        output lpif_beat_data,
        output lpif_beat_vld,
        input  lpif_beat_rdy,
        input  txfifo_downstream_data,
        input  txfifo_downstream_vld,
        output txfifo_downstream_rdy
    );
endinterface

// File: rtl/lpif_tx_asym2_pack_ctrl.sv
// ---------------------------------------------------------------------------
// lpif_tx_asym2_pack_ctrl
// Sequencer ahead of the x4 asym2 half-rate LPIF-to-LLINK packing (master TX).
// Pairs two consecutive 77-bit LPIF beats into one 154-bit TX FIFO word
// (first beat low, second beat high). In Gen2 mode each beat is forwarded
// alone with a zero upper half. A lone held beat can be flushed as a partial
// word by flush_req, by a mode change, or (optionally) by an idle timeout.
//
// Ports:
//   clk_wr              clock
//   rst_wr              synchronous active-high reset
//   m_gen2_mode         1 = unpaired (1:1), 0 = asym2 pairing
//   flush_req           level request to emit a held half word
//   bus (slave)         beat input stream and TX FIFO word output stream
//   pack_busy           high while one beat is held (state HALF)
//   partial_flush_cnt   saturating count of partial words emitted
//
// Optional feature: define LPIF_PACK_TIMEOUT_EN to auto-flush a held beat
// TIMEOUT_CYC cycles after it was accepted when no partner beat arrives.
// ---------------------------------------------------------------------------
module lpif_tx_asym2_pack_ctrl #(
    parameter int BEAT_W      = 77,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr,
    input  logic                 m_gen2_mode,
    input  logic                 flush_req,
    lpif_tx_asym2_pack_if.slave  bus,
    output logic                 pack_busy,
    output logic [CNT_W-1:0]     partial_flush_cnt
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_e;

    state_e            state;
    logic [BEAT_W-1:0] lo;
    logic              mode_q;

    logic out_free;
    logic mode_chg;
    logic accept;
    logic timeout_hit;
    logic flush_cond;

    // The single output register can take a new word when it is empty or
    // being drained this cycle.
    assign out_free = !bus.txfifo_downstream_vld || bus.txfifo_downstream_rdy;

    // A mode flip while a beat is held must flush that beat under the old
    // mode first, so new beats are refused until the state is back to EMPTY.
    assign mode_chg          = (state == ST_HALF) && (m_gen2_mode != mode_q);
    assign bus.lpif_beat_rdy = out_free && !mode_chg;
    assign accept            = bus.lpif_beat_vld && bus.lpif_beat_rdy;

`ifdef LPIF_PACK_TIMEOUT_EN
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] idle_cnt;

    assign timeout_hit = (state == ST_HALF) && (idle_cnt == IDLE_LAST);

    // Entry to HALF always coincides with an accept, so clearing on accept
    // also covers the entry case. The counter parks at its last value so a
    // back-pressured timeout flush keeps retrying.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            idle_cnt <= '0;
        end else if (accept || state == ST_EMPTY) begin
            idle_cnt <= '0;
        end else if (!timeout_hit) begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign flush_cond = flush_req || mode_chg || timeout_hit;

    // NOTE: state is updated with non-blocking assignments so every branch
    // below sees the pre-edge values of state, lo and the output register.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            state                      <= ST_EMPTY;
            lo                         <= '0;
            mode_q                     <= 1'b0;
            bus.txfifo_downstream_data <= '0;
            bus.txfifo_downstream_vld  <= 1'b0;
            pack_busy                  <= 1'b0;
            partial_flush_cnt          <= '0;
        end else begin
            // Drained words clear vld; any branch loading a word overrides it.
            if (bus.txfifo_downstream_rdy) begin
                bus.txfifo_downstream_vld <= 1'b0;
            end

            // The mode copy tracks the input only while nothing is held.
            if (state == ST_EMPTY) begin
                mode_q <= m_gen2_mode;
            end

            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        if (m_gen2_mode) begin
                            bus.txfifo_downstream_data <= {{BEAT_W{1'b0}}, bus.lpif_beat_data};
                            bus.txfifo_downstream_vld  <= 1'b1;
                        end else begin
                            lo        <= bus.lpif_beat_data;
                            state     <= ST_HALF;
                            pack_busy <= 1'b1;
                        end
                    end
                end

                ST_HALF: begin
                    // A partner beat takes priority over any flush source.
                    if (accept) begin
                        bus.txfifo_downstream_data <= {bus.lpif_beat_data, lo};
                        bus.txfifo_downstream_vld  <= 1'b1;
                        state                      <= ST_EMPTY;
                        pack_busy                  <= 1'b0;
                    end else if (flush_cond && out_free) begin
                        bus.txfifo_downstream_data <= {{BEAT_W{1'b0}}, lo};
                        bus.txfifo_downstream_vld  <= 1'b1;
                        state                      <= ST_EMPTY;
                        pack_busy                  <= 1'b0;
                        if (partial_flush_cnt != '1) begin
                            partial_flush_cnt <= partial_flush_cnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpif_tx_asym2_pack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lpif_tx_asym2_pack_ctrl
// Self-checking bench for lpif_tx_asym2_pack_ctrl: directed scenario tasks
// followed by a randomized run against a transaction-level reference model
// (held beat + queue of expected FIFO words).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_lpif_tx_asym2_pack_ctrl;

    localparam int BW = 77;
    localparam int WW = 154;
    localparam int TO = 16;
`ifdef LPIF_PACK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk_wr = 1'b0;
    logic        rst_wr;
    logic        m_gen2_mode;
    logic        flush_req;
    logic        pack_busy;
    logic [15:0] partial_flush_cnt;

    int vectors     = 0;
    int miscompares = 0;

    lpif_tx_asym2_pack_if #(.BEAT_W(BW)) bus ();

    lpif_tx_asym2_pack_ctrl #(
        .BEAT_W      (BW),
        .CNT_W       (16),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_wr            (clk_wr),
        .rst_wr            (rst_wr),
        .m_gen2_mode       (m_gen2_mode),
        .flush_req         (flush_req),
        .bus               (bus.slave),
        .pack_busy         (pack_busy),
        .partial_flush_cnt (partial_flush_cnt)
    );

    always #5 clk_wr = ~clk_wr;

    // Beat with recognisable payload; other fields fixed but non-zero.
    function automatic logic [BW-1:0] mk_beat(input logic [63:0] d);
        mk_beat = {1'b1, 1'b1, 4'hA, 1'b1, d, 2'b10, 4'h5};
    endfunction

    // Called at posedge+1: drives inputs, samples handshakes before the
    // next edge, then advances to the next posedge+1.
    task automatic drive_cycle(input logic bvld, input logic [BW-1:0] beat,
                               input logic flush, input logic gen2, input logic frdy,
                               output logic acc, output logic got, output logic [WW-1:0] word);
        bus.lpif_beat_vld         = bvld;
        bus.lpif_beat_data        = beat;
        flush_req                 = flush;
        m_gen2_mode               = gen2;
        bus.txfifo_downstream_rdy = frdy;
        #2;
        acc  = bvld && bus.lpif_beat_rdy;
        got  = bus.txfifo_downstream_vld && frdy;
        word = bus.txfifo_downstream_data;
        @(posedge clk_wr);
        #1;
    endtask

    task automatic do_reset();
        rst_wr                    = 1'b1;
        m_gen2_mode               = 1'b0;
        flush_req                 = 1'b0;
        bus.lpif_beat_vld         = 1'b0;
        bus.lpif_beat_data        = '0;
        bus.txfifo_downstream_rdy = 1'b1;
        @(posedge clk_wr);
        #1;
        @(posedge clk_wr);
        #1;
        rst_wr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        vectors++;
        if (bus.lpif_beat_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_rdy: got %b exp 1", bus.lpif_beat_rdy);
        end
        vectors++;
        if (bus.txfifo_downstream_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_vld: got %b exp 0", bus.txfifo_downstream_vld);
        end
        vectors++;
        if (bus.txfifo_downstream_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h exp 0", bus.txfifo_downstream_data);
        end
        vectors++;
        if (pack_busy !== 1'b0 || partial_flush_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_busy_cnt: got %b/%0d exp 0/0", pack_busy, partial_flush_cnt);
        end
        @(posedge clk_wr);
        #1;
    endtask

    task automatic test_pairing();
        logic acc, got;
        logic [WW-1:0] w;
        logic [BW-1:0] a, b;
        a = mk_beat(64'h1);
        b = mk_beat(64'h2);
        do_reset();
        drive_cycle(1'b1, a, 1'b0, 1'b0, 1'b1, acc, got, w);
        vectors++;
        if (acc !== 1'b1 || pack_busy !== 1'b1 || bus.txfifo_downstream_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL pair_first: acc/busy/vld got %b%b%b exp 110", acc, pack_busy, bus.txfifo_downstream_vld);
        end
        drive_cycle(1'b1, b, 1'b0, 1'b0, 1'b1, acc, got, w);
        vectors++;
        if (acc !== 1'b1 || pack_busy !== 1'b0 || bus.txfifo_downstream_vld !== 1'b1) begin
            miscompares++;
            $display("FAIL pair_second: acc/busy/vld got %b%b%b exp 101", acc, pack_busy, bus.txfifo_downstream_vld);
        end
        vectors++;
        if (bus.txfifo_downstream_data[6 +: 64] !== 64'h1 || bus.txfifo_downstream_data[83 +: 64] !== 64'h2) begin
            miscompares++;
            $display("FAIL pair_payload: got lo %h hi %h exp 1/2",
                     bus.txfifo_downstream_data[6 +: 64], bus.txfifo_downstream_data[83 +: 64]);
        end
        vectors++;
        if (bus.txfifo_downstream_data !== {b, a}) begin
            miscompares++;
            $display("FAIL pair_word: got %h exp %h", bus.txfifo_downstream_data, {b, a});
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc, got, w);
        vectors++;
        if (got !== 1'b1 || bus.txfifo_downstream_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL pair_drain: got/vld %b%b exp 10", got, bus.txfifo_downstream_vld);
        end
    endtask

    task automatic test_back_pressure();
        logic acc, got;
        logic [WW-1:0] w;
        logic [BW-1:0] beats [6];
        logic [WW-1:0] words [$];
        int idx;
        for (int i = 0; i < 6; i++) beats[i] = mk_beat(64'h100 + 64'(i));
        do_reset();
        drive_cycle(1'b1, beats[0], 1'b0, 1'b0, 1'b0, acc, got, w);
        drive_cycle(1'b1, beats[1], 1'b0, 1'b0, 1'b0, acc, got, w);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, beats[2], 1'b0, 1'b0, 1'b0, acc, got, w);
            vectors++;
            if (acc !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_rdy_low: accepted while output full (cycle %0d)", i);
            end
            vectors++;
            if (bus.txfifo_downstream_vld !== 1'b1 || bus.txfifo_downstream_data !== {beats[1], beats[0]}) begin
                miscompares++;
                $display("FAIL bp_hold: vld %b data %h exp 1 %h", bus.txfifo_downstream_vld,
                         bus.txfifo_downstream_data, {beats[1], beats[0]});
            end
        end
        idx = 2;
        for (int c = 0; c < 12; c++) begin
            drive_cycle(idx < 6, (idx < 6) ? beats[idx] : '0, 1'b0, 1'b0, 1'b1, acc, got, w);
            if (acc) idx++;
            if (got) words.push_back(w);
        end
        vectors++;
        if (idx !== 6 || words.size() !== 3) begin
            miscompares++;
            $display("FAIL bp_counts: beats %0d words %0d exp 6/3", idx, words.size());
        end
        for (int i = 0; i < words.size() && i < 3; i++) begin
            vectors++;
            if (words[i] !== {beats[2*i+1], beats[2*i]}) begin
                miscompares++;
                $display("FAIL bp_order[%0d]: got %h exp %h", i, words[i], {beats[2*i+1], beats[2*i]});
            end
        end
    endtask

    task automatic test_flush();
        logic acc, got;
        logic [WW-1:0] w;
        logic [BW-1:0] c, c2, d2;
        c  = mk_beat(64'hC);
        c2 = mk_beat(64'hC2);
        d2 = mk_beat(64'hD2);
        do_reset();
        drive_cycle(1'b1, c, 1'b0, 1'b0, 1'b1, acc, got, w);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, acc, got, w);
        vectors++;
        if (bus.txfifo_downstream_vld !== 1'b1 || bus.txfifo_downstream_data !== {{BW{1'b0}}, c}) begin
            miscompares++;
            $display("FAIL flush_word: vld %b data %h exp 1 %h", bus.txfifo_downstream_vld,
                     bus.txfifo_downstream_data, {{BW{1'b0}}, c});
        end
        vectors++;
        if (bus.txfifo_downstream_data[153] !== 1'b0 || partial_flush_cnt !== 16'd1 || pack_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_cnt: bit153 %b cnt %0d busy %b exp 0/1/0",
                     bus.txfifo_downstream_data[153], partial_flush_cnt, pack_busy);
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, acc, got, w);
            vectors++;
            if (bus.txfifo_downstream_vld !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_empty_ignored: vld %b exp 0 (cycle %0d)", bus.txfifo_downstream_vld, i);
            end
        end
        drive_cycle(1'b1, c2, 1'b0, 1'b0, 1'b1, acc, got, w);
        drive_cycle(1'b1, d2, 1'b1, 1'b0, 1'b1, acc, got, w);
        vectors++;
        if (bus.txfifo_downstream_data !== {d2, c2} || partial_flush_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL flush_vs_accept: data %h cnt %0d exp %h/1", bus.txfifo_downstream_data,
                     partial_flush_cnt, {d2, c2});
        end
    endtask

    task automatic test_gen2();
        logic acc, got;
        logic [WW-1:0] w;
        logic [BW-1:0] d, e;
        d = mk_beat(64'hD);
        e = mk_beat(64'hE);
        do_reset();
        drive_cycle(1'b1, d, 1'b0, 1'b1, 1'b1, acc, got, w);
        vectors++;
        if (bus.txfifo_downstream_vld !== 1'b1 || bus.txfifo_downstream_data !== {{BW{1'b0}}, d} || pack_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL gen2_d: vld %b data %h busy %b exp 1 %h 0", bus.txfifo_downstream_vld,
                     bus.txfifo_downstream_data, pack_busy, {{BW{1'b0}}, d});
        end
        drive_cycle(1'b1, e, 1'b0, 1'b1, 1'b1, acc, got, w);
        vectors++;
        if (bus.txfifo_downstream_vld !== 1'b1 || bus.txfifo_downstream_data !== {{BW{1'b0}}, e}) begin
            miscompares++;
            $display("FAIL gen2_e: vld %b data %h exp 1 %h", bus.txfifo_downstream_vld,
                     bus.txfifo_downstream_data, {{BW{1'b0}}, e});
        end
        vectors++;
        if (partial_flush_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL gen2_cnt: got %0d exp 0", partial_flush_cnt);
        end
    endtask

    task automatic test_mode_change();
        logic acc, got;
        logic [WW-1:0] w;
        logic [BW-1:0] g, h;
        g = mk_beat(64'h6);
        h = mk_beat(64'h7);
        do_reset();
        drive_cycle(1'b1, g, 1'b0, 1'b0, 1'b1, acc, got, w);
        drive_cycle(1'b1, h, 1'b0, 1'b1, 1'b1, acc, got, w);
        vectors++;
        if (acc !== 1'b0) begin
            miscompares++;
            $display("FAIL mode_rdy_low: accepted during mode change");
        end
        vectors++;
        if (bus.txfifo_downstream_data !== {{BW{1'b0}}, g} || partial_flush_cnt !== 16'd1 || pack_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mode_flush: data %h cnt %0d busy %b exp %h/1/0", bus.txfifo_downstream_data,
                     partial_flush_cnt, pack_busy, {{BW{1'b0}}, g});
        end
        drive_cycle(1'b1, h, 1'b0, 1'b1, 1'b1, acc, got, w);
        vectors++;
        if (acc !== 1'b1 || bus.txfifo_downstream_data !== {{BW{1'b0}}, h} || partial_flush_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL mode_new_beat: acc %b data %h cnt %0d exp 1 %h 1", acc,
                     bus.txfifo_downstream_data, partial_flush_cnt, {{BW{1'b0}}, h});
        end
    endtask

    task automatic test_timeout();
        logic acc, got;
        logic [WW-1:0] w;
        logic [BW-1:0] j, k, l;
        int first;
        j = mk_beat(64'hA1);
        k = mk_beat(64'hB1);
        l = mk_beat(64'hB2);
        do_reset();
        drive_cycle(1'b1, j, 1'b0, 1'b0, 1'b1, acc, got, w);
        first = -1;
        for (int c = 1; c <= 40; c++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc, got, w);
            if (first < 0 && bus.txfifo_downstream_vld === 1'b1) begin
                first = c;
                vectors++;
                if (bus.txfifo_downstream_data !== {{BW{1'b0}}, j}) begin
                    miscompares++;
                    $display("FAIL timeout_word: got %h exp %h", bus.txfifo_downstream_data, {{BW{1'b0}}, j});
                end
            end
        end
        vectors++;
        if (TO_EN) begin
            if (first !== TO) begin
                miscompares++;
                $display("FAIL timeout_latency: got %0d exp %0d", first, TO);
            end
        end else if (first !== -1 || pack_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL no_timeout_hold: first %0d busy %b exp -1/1", first, pack_busy);
        end
        do_reset();
        drive_cycle(1'b1, k, 1'b0, 1'b0, 1'b1, acc, got, w);
        for (int c = 1; c < 10; c++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc, got, w);
        drive_cycle(1'b1, l, 1'b0, 1'b0, 1'b1, acc, got, w);
        vectors++;
        if (bus.txfifo_downstream_data !== {l, k} || partial_flush_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL timeout_late_pair: data %h cnt %0d exp %h/0", bus.txfifo_downstream_data,
                     partial_flush_cnt, {l, k});
        end
    endtask

    task automatic test_reset_mid_op();
        logic acc, got;
        logic [WW-1:0] w;
        logic [BW-1:0] x, a, b, c, d;
        x = mk_beat(64'h51);
        a = mk_beat(64'h52);
        b = mk_beat(64'h53);
        c = mk_beat(64'h54);
        d = mk_beat(64'h55);
        do_reset();
        drive_cycle(1'b1, x, 1'b0, 1'b0, 1'b1, acc, got, w);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, acc, got, w);
        drive_cycle(1'b1, a, 1'b0, 1'b0, 1'b1, acc, got, w);
        rst_wr = 1'b1;
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc, got, w);
        rst_wr = 1'b0;
        vectors++;
        if (bus.txfifo_downstream_vld !== 1'b0 || pack_busy !== 1'b0 || partial_flush_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_mid_half: vld %b busy %b cnt %0d exp 0/0/0", bus.txfifo_downstream_vld,
                     pack_busy, partial_flush_cnt);
        end
        drive_cycle(1'b1, b, 1'b0, 1'b0, 1'b1, acc, got, w);
        drive_cycle(1'b1, c, 1'b0, 1'b0, 1'b1, acc, got, w);
        vectors++;
        if (bus.txfifo_downstream_data !== {c, b}) begin
            miscompares++;
            $display("FAIL rst_mid_discard: got %h exp %h", bus.txfifo_downstream_data, {c, b});
        end
        drive_cycle(1'b1, d, 1'b0, 1'b1, 1'b0, acc, got, w);
        rst_wr = 1'b1;
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc, got, w);
        rst_wr = 1'b0;
        vectors++;
        if (bus.txfifo_downstream_vld !== 1'b0 || bus.txfifo_downstream_data !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_word: vld %b data %h exp 0/0", bus.txfifo_downstream_vld,
                     bus.txfifo_downstream_data);
        end
    endtask

    // Randomized run against a transaction-level model: a possibly-held beat
    // plus the queue of words the FIFO side should still see.
    task automatic test_random();
        logic [WW-1:0] mq [$];
        logic          held;
        logic [BW-1:0] hold;
        int            age;
        logic [15:0]   mcnt;
        logic          gen2, bvld, fl, frdy;
        logic [BW-1:0] beat;
        logic          exp_vld, out_free, mchg, erdy, acc, to_hit;
        do_reset();
        held = 1'b0;
        hold = '0;
        age  = 0;
        mcnt = 16'd0;
        gen2 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bvld = ($urandom_range(0, 9) < 6);
            beat = {13'($urandom), $urandom, $urandom};
            fl   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) gen2 = ~gen2;
            frdy = ($urandom_range(0, 9) < 7);
            bus.lpif_beat_vld         = bvld;
            bus.lpif_beat_data        = beat;
            flush_req                 = fl;
            m_gen2_mode               = gen2;
            bus.txfifo_downstream_rdy = frdy;
            #2;
            exp_vld = (mq.size() != 0);
            vectors++;
            if (bus.txfifo_downstream_vld !== exp_vld) begin
                miscompares++;
                $display("FAIL rnd_vld[%0d]: got %b exp %b", n, bus.txfifo_downstream_vld, exp_vld);
            end
            if (exp_vld) begin
                vectors++;
                if (bus.txfifo_downstream_data !== mq[0]) begin
                    miscompares++;
                    $display("FAIL rnd_data[%0d]: got %h exp %h", n, bus.txfifo_downstream_data, mq[0]);
                end
            end
            vectors++;
            if (pack_busy !== held || partial_flush_cnt !== mcnt) begin
                miscompares++;
                $display("FAIL rnd_busy_cnt[%0d]: got %b/%0d exp %b/%0d", n, pack_busy, partial_flush_cnt, held, mcnt);
            end
            out_free = !exp_vld || frdy;
            if (exp_vld && frdy) void'(mq.pop_front());
            mchg = held && gen2;
            erdy = out_free && !mchg;
            vectors++;
            if (bus.lpif_beat_rdy !== erdy) begin
                miscompares++;
                $display("FAIL rnd_rdy[%0d]: got %b exp %b", n, bus.lpif_beat_rdy, erdy);
            end
            acc    = bvld && erdy;
            to_hit = TO_EN && held && (age == TO - 1);
            if (held) begin
                if (acc) begin
                    mq.push_back({beat, hold});
                    held = 1'b0;
                end else if ((fl || mchg || to_hit) && out_free) begin
                    mq.push_back({{BW{1'b0}}, hold});
                    held = 1'b0;
                    if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
                end else if (!to_hit) begin
                    age = age + 1;
                end
            end else if (acc) begin
                if (gen2) begin
                    mq.push_back({{BW{1'b0}}, beat});
                end else begin
                    held = 1'b1;
                    hold = beat;
                    age  = 0;
                end
            end
            @(posedge clk_wr);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_pairing();
        test_back_pressure();
        test_flush();
        test_gen2();
        test_mode_change();
        test_timeout();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lpif_tx_asym2_pack_ctrl.md
Name: lpif_tx_asym2_pack_ctrl

Overview:
- Sequencer ahead of the x4 asym2 half-rate LPIF-to-LLINK packing on the master TX side.
- Accepts single 77-bit LPIF beats and pairs two consecutive beats into one 154-bit TX FIFO word: first beat in the lower half, second in the upper half.
- Handles back-pressure from the TX FIFO, partial-word flush, and Gen2 (1:1, unpaired) mode.
- Tracks flush statistics.

Parameters:
- BEAT_W, 77, width of one LPIF beat.
- CNT_W, 16, width of the partial-flush counter.
- TIMEOUT_CYC, 16, idle cycles in HALF before auto-flush; only used with LPIF_PACK_TIMEOUT_EN; legal range 2..255.

Ports:
- clk_wr  in  1  clock.
- rst_wr  in  1  reset; one clock, synchronous, active-high.
- m_gen2_mode  in  1  1 = unpaired (1:1) mode; 0 = asym2 pairing.
- lpif_beat_data  in  77  one beat, packed as:
  - state [0+:4]
  - protid [4+:2]
  - data [6+:64]
  - dvalid [70]
  - crc [71+:4]
  - crc_valid [75]
  - valid [76]
- lpif_beat_vld  in  1  beat offered.
- lpif_beat_rdy  out  1  beat accepted when vld & rdy.
- flush_req  in  1  level request to emit a pending half word.
- txfifo_downstream_data  out  154  packed word; upper 77 bits are the second beat.
- txfifo_downstream_vld  out  1  word valid.
- txfifo_downstream_rdy  in  1  FIFO accepts when vld & rdy.
- pack_busy  out  1  high while one beat is held (state HALF).
- partial_flush_cnt  out  CNT_W  saturating count of words emitted with an empty upper half in pairing mode.

Behaviour:
- Reset values:
  - state EMPTY.
  - txfifo_downstream_data = 0, txfifo_downstream_vld = 0, pack_busy = 0, partial_flush_cnt = 0.
  - Holding register lo = 0.
  - lpif_beat_rdy = 1 from the first cycle after reset deasserts.
- Output stage: single register.
  - out_free = !txfifo_downstream_vld | txfifo_downstream_rdy.
  - lpif_beat_rdy = out_free & !mode_chg.
  - mode_chg = m_gen2_mode differs from its registered copy while in HALF.
- Data/vld hold: txfifo_downstream_data/vld are held stable until accepted. vld never drops without rdy.
- States: EMPTY, HALF.
  - EMPTY, accept, gen2=0: lo <= beat; go HALF. No output.
  - EMPTY, accept, gen2=1: out <= {77'b0, beat}; vld <= 1; stay EMPTY. Latency 1 cycle.
  - HALF, accept: out <= {beat, lo}; vld <= 1; go EMPTY. Latency 1 cycle after the second beat.
  - HALF, no accept, flush condition & out_free: out <= {77'b0, lo}; vld <= 1; go EMPTY; partial_flush_cnt++ (saturates at all-ones).
  - Flush condition = flush_req | mode_chg | timeout (timeout only with the macro).
  - HALF, flush condition & !out_free: stay HALF; retried each cycle.
- Simultaneous accept and flush_req in HALF: accept wins and the word is a full pair; flush_req is a no-op that cycle.
- flush_req in EMPTY: ignored.
- If no new word is loaded and txfifo_downstream_rdy=1, vld <= 0.
- Mode change:
  - The registered m_gen2_mode copy updates only in EMPTY.
  - A change seen in HALF forces a flush of lo under the old mode before any new beat is accepted.
- Reset mid-operation: a held beat and an unaccepted output word are discarded. No partial word is emitted.

Optional Feature:
- Macro: LPIF_PACK_TIMEOUT_EN.
- Defined:
  - An 8-bit idle counter clears on entry to HALF and on any accept.
  - It increments each cycle in HALF with no accept.
  - When the counter equals TIMEOUT_CYC-1, the flush condition is raised.
  - Flush is therefore issued TIMEOUT_CYC cycles after the first beat when no second beat arrives and out_free holds.
- Not defined: no counter. A HALF state persists until a second beat, flush_req, or a mode change.

Test Plan:
- Pairing: gen2=0, rdy=1; beats A (data=64'h1) then B (data=64'h2) on consecutive cycles.
  -> one word, vld 1 cycle after B, data[6+:64]=1, data[83+:64]=2; busy high for 1 cycle.
- Back-pressure: rdy=0 with a word pending, then 4 more beats offered.
  -> lpif_beat_rdy=0 whenever the output is full; word held stable; releasing rdy delivers the words in order with no loss or duplication.
- Flush: one beat C, then flush_req=1.
  -> word {77'b0, C}; bit 153=0; partial_flush_cnt=1. flush_req in EMPTY -> no output.
- Gen2: gen2=1; beats D, E.
  -> two words, each with the upper half zero; partial_flush_cnt unchanged. Toggling the mode while in HALF -> held beat flushed first, rdy low for that cycle.
- Timeout (macro on, TIMEOUT_CYC=16): one beat, then idle.
  -> partial word emitted exactly 16 cycles after acceptance. A second beat at cycle 10 -> full pair, no flush.
- Reset mid-op: rst_wr pulsed while in HALF with vld=1.
  -> next cycle vld=0, busy=0, cnt=0; the held beat never appears.
